// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers used by the S-box lanes.
// The S-box is computed arithmetically (field inverse plus affine map), so no table is stored.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NBYTES  = 16;

    localparam logic SBOX_MODE_ENC = 1'b1;
    localparam logic SBOX_MODE_DEC = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] acc;
        pw  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            acc = gf_mul(acc, pw);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_affine(input logic [7:0] x);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv_affine(input logic [7:0] x);
        return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward and inverse AES byte S-boxes, purely combinational.
// Both are built from the same field inverse; only the affine step differs and its order.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    assign data_o = sbox_affine(gf_inv(data_i));

endmodule

module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    assign data_o = gf_inv(sbox_inv_affine(data_i));

endmodule

// File: rtl/aes_sbox_lane.sv
// One shared byte lane: forward and inverse S-box side by side, selected by the latched mode.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       mode_i,
    output logic [7:0] data_o
);

    logic [7:0] fwd_out;
    logic [7:0] inv_out;

    aes_sbox u_fwd (
        .data_i (data_i),
        .data_o (fwd_out)
    );

    aes_inv_sbox u_inv (
        .data_i (data_i),
        .data_o (inv_out)
    );

    assign data_o = (mode_i == SBOX_MODE_DEC) ? inv_out : fwd_out;

endmodule

// File: rtl/aes_subbytes_iter_shared.sv
// Iterative SubBytes/InvSubBytes over a 128-bit state using LANES shared byte lanes,
// one chunk of LANES bytes per cycle, with valid/ready handshakes on input and output.
module aes_subbytes_iter_shared
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   enc_dec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    localparam int NCHUNK  = AES_NBYTES / LANES;
    localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CHUNK_W = 8 * LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
        $error("aes_subbytes_iter_shared: LANES must be 1, 2, 4, 8 or 16");
    end

    aes_fsm_e               state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] data_q, data_d;
    logic                   mode_q, mode_d;

    logic [CHUNK_W-1:0]     chunk_in;
    logic [CHUNK_W-1:0]     chunk_out;
    logic                   accept;

    // Chunk 0 is the most significant slice, so byte 0 sits at [127:120].
    always_comb begin
        chunk_in = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            if (cnt_q == CNT_W'(c)) begin
                chunk_in = data_q[AES_STATE_W-1-c*CHUNK_W -: CHUNK_W];
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        aes_sbox_lane u_lane (
            .data_i (chunk_in[CHUNK_W-1-8*gi -: 8]),
            .mode_i (mode_q),
            .data_o (chunk_out[CHUNK_W-1-8*gi -: 8])
        );
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mode_d  = mode_q;

        case (state_q)
            IDLE: begin
            end
            BUSY: begin
                for (int c = 0; c < NCHUNK; c++) begin
                    if (cnt_q == CNT_W'(c)) begin
                        data_d[AES_STATE_W-1-c*CHUNK_W -: CHUNK_W] = chunk_out;
                    end
                end
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new block may be taken from IDLE or on the same edge the result drains.
        if (accept) begin
            data_d  = in_data;
            mode_d  = enc_dec;
            cnt_d   = '0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= SBOX_MODE_ENC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_aes_subbytes_iter_shared.sv
// Directed and streamed checks of the iterative SubBytes engine against the FIPS-197 S-box table.
module tb_aes_subbytes_iter_shared;

    localparam int NRAND = 1000;
    localparam logic [127:0] V_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V_CT  = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] V_53  = {16{8'h53}};
    localparam logic [127:0] V_ED  = {16{8'hed}};
    localparam int SW_LAT [4] = '{16, 8, 2, 1};

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, enc_dec, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;

    logic         sw_in_valid;
    logic [127:0] sw_in_data;
    logic [3:0]   sw_in_ready, sw_out_valid, sw_busy;
    logic [127:0] sw_out_data [4];

    logic [7:0]   sbox_tab [256];
    logic [7:0]   inv_tab  [256];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    aes_subbytes_iter_shared #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .enc_dec   (enc_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int LN = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
        aes_subbytes_iter_shared #(.LANES(LN)) u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_in_valid),
            .in_ready  (sw_in_ready[gi]),
            .in_data   (sw_in_data),
            .enc_dec   (1'b1),
            .out_valid (sw_out_valid[gi]),
            .out_ready (1'b1),
            .out_data  (sw_out_data[gi]),
            .busy      (sw_busy[gi])
        );
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int max_cyc, output int lat);
        lat = 0;
        while (!out_valid && lat < max_cyc) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic m);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = d[127-8*i -: 8];
            r[127-8*i -: 8] = m ? sbox_tab[b] : inv_tab[b];
        end
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int sw_lat [4];
        logic [127:0] sw_cap [4];
        logic [127:0] exp_q [$];
        logic [127:0] rdata;
        logic         rmode, have;
        int           sent, recv, cyc;

        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                sbox_tab[r*16+c] = SBOX_ROWS[r][127-8*c -: 8];
            end
        end
        for (int i = 0; i < 256; i++) begin
            inv_tab[sbox_tab[i]] = 8'(i);
        end

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; enc_dec = 1'b1; out_ready = 1'b0;
        sw_in_valid = 1'b0; sw_in_data = '0;

        // Reset state
        step();
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_busy", 128'(busy), 128'(0));
        step();
        rst_n = 1'b1;
        step();
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        $display("txn reset done");

        // Encrypt vector, latency and single-cycle valid
        in_data = V_PT; enc_dec = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("enc_busy", 128'(busy), 128'(1));
        check_eq("enc_in_ready_busy", 128'(in_ready), 128'(0));
        wait_out(32, lat);
        check_eq("enc_latency", 128'(lat), 128'(4));
        check_eq("enc_data", out_data, V_CT);
        step();
        check_eq("enc_valid_one_cycle", 128'(out_valid), 128'(0));
        $display("txn enc in=%h out=%h lat=%0d", V_PT, out_data, lat);

        // Decrypt vector with enc_dec toggling mid-flight
        in_data = V_CT; enc_dec = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 32) begin
            enc_dec = ~enc_dec;
            step();
            lat++;
        end
        check_eq("dec_latency", 128'(lat), 128'(4));
        check_eq("dec_data", out_data, V_PT);
        step();
        $display("txn dec in=%h out=%h lat=%0d", V_CT, out_data, lat);

        // Backpressure then same-edge accept
        out_ready = 1'b0; in_data = V_PT; enc_dec = 1'b1; in_valid = 1'b1;
        step();
        in_data = V_53; enc_dec = 1'b1; in_valid = 1'b1;
        wait_out(32, lat);
        check_eq("bp_latency", 128'(lat), 128'(4));
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_hold_valid", 128'(out_valid), 128'(1));
            check_eq("bp_hold_data", out_data, V_CT);
            check_eq("bp_in_ready", 128'(in_ready), 128'(0));
            step();
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_comb", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        check_eq("b2b_valid_drop", 128'(out_valid), 128'(0));
        check_eq("b2b_busy", 128'(busy), 128'(1));
        wait_out(32, lat);
        check_eq("b2b_latency", 128'(lat), 128'(4));
        check_eq("b2b_data", out_data, V_ED);
        step();
        $display("txn backpressure b2b out=%h lat=%0d", V_ED, lat);

        // Asynchronous reset mid-operation
        in_data = V_PT; enc_dec = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 128'(out_valid), 128'(0));
        check_eq("arst_out_data", out_data, '0);
        check_eq("arst_busy", 128'(busy), 128'(0));
        step();
        step();
        rst_n = 1'b1;
        step();
        check_eq("arst_in_ready", 128'(in_ready), 128'(1));
        in_data = V_CT; enc_dec = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(32, lat);
        check_eq("arst_fresh_latency", 128'(lat), 128'(4));
        check_eq("arst_fresh_data", out_data, V_PT);
        step();
        $display("txn reset-mid-op fresh out=%h lat=%0d", V_PT, lat);

        // LANES sweep 1/2/8/16
        sw_in_data = V_PT; sw_in_valid = 1'b1;
        #1;
        check_eq("sw_in_ready", 128'(sw_in_ready), 128'(4'hf));
        step();
        sw_in_valid = 1'b0;
        check_eq("sw_busy", 128'(sw_busy), 128'(4'hf));
        for (int i = 0; i < 4; i++) begin
            sw_lat[i] = 0;
            sw_cap[i] = '0;
        end
        for (int c = 1; c <= 20; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (sw_out_valid[i] && sw_lat[i] == 0) begin
                    sw_lat[i] = c;
                    sw_cap[i] = sw_out_data[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("sw%0d_latency", i), 128'(sw_lat[i]), 128'(SW_LAT[i]));
            check_eq($sformatf("sw%0d_data", i), sw_cap[i], V_CT);
            $display("txn sweep lanes_idx=%0d out=%h lat=%0d", i, sw_cap[i], sw_lat[i]);
        end

        // Randomised streaming against the table model
        sent = 0; recv = 0; cyc = 0; have = 1'b0; rdata = '0; rmode = 1'b1;
        while (recv < NRAND && cyc < 40000) begin
            if (!have && sent < NRAND && $urandom_range(3) != 0) begin
                have  = 1'b1;
                rdata = {$urandom, $urandom, $urandom, $urandom};
                rmode = 1'($urandom_range(1));
            end
            in_valid  = have;
            in_data   = rdata;
            enc_dec   = have ? rmode : 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                check_eq("rand_q_nonempty", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    check_eq($sformatf("rand_blk%0d", recv), out_data, exp_q.pop_front());
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sub(rdata, rmode));
                sent++;
                have = 1'b0;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("rand_sent", 128'(sent), 128'(NRAND));
        check_eq("rand_recv", 128'(recv), 128'(NRAND));
        check_eq("rand_q_drained", 128'(exp_q.size()), 128'(0));
        $display("txn random stream sent=%0d recv=%0d cycles=%0d", sent, recv, cyc);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
